// File: rtl/pipelined_add_sub.sv
// Pipelined two's-complement adder/subtractor that resolves one CHUNK-bit slice per stage.
// Define SATURATE_EN to clamp the sum to the signed limits when overflow is reported.
module pipelined_add_sub #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic             overflow
);
    localparam int STAGES = WIDTH / CHUNK;

    // Handshake: a beat moves on a side when its valid and ready are both high at the rising edge;
    // the whole pipeline advances together whenever the output slot is empty or being drained.
    logic adv;

    // Per-stage registers: skewed operands, partial result, slice carry, valid.
    logic [WIDTH-1:0] a_q [STAGES];
    logic [WIDTH-1:0] b_q [STAGES];
    logic [WIDTH-1:0] r_q [STAGES];
    logic             c_q [STAGES];
    logic             v_q [STAGES];
    logic             ov_q;

    logic [WIDTH-1:0] a_d [STAGES];
    logic [WIDTH-1:0] b_d [STAGES];
    logic [WIDTH-1:0] r_d [STAGES];
    logic             c_d [STAGES];
    logic             v_d [STAGES];
    logic             ov_d;

    // Inputs seen by each stage: the ports for stage 0, the previous stage otherwise.
    logic [WIDTH-1:0] a_s [STAGES];
    logic [WIDTH-1:0] b_s [STAGES];
    logic [WIDTH-1:0] r_s [STAGES];
    logic             c_s [STAGES];
    logic             v_s [STAGES];

    logic [CHUNK:0]   slice;
    logic             msb_cin;

    assign a_s[0] = a;
    assign b_s[0] = b ^ {WIDTH{mode}};
    assign c_s[0] = mode;
    assign r_s[0] = '0;
    assign v_s[0] = in_valid;

    for (genvar k = 1; k < STAGES; k++) begin : g_link
        assign a_s[k] = a_q[k-1];
        assign b_s[k] = b_q[k-1];
        assign r_s[k] = r_q[k-1];
        assign c_s[k] = c_q[k-1];
        assign v_s[k] = v_q[k-1];
    end

    always_comb begin
        a_d     = a_q;
        b_d     = b_q;
        r_d     = r_q;
        c_d     = c_q;
        v_d     = v_q;
        ov_d    = ov_q;
        slice   = '0;
        msb_cin = 1'b0;
        for (int k = 0; k < STAGES; k++) begin
            slice = {1'b0, a_s[k][k*CHUNK +: CHUNK]}
                  + {1'b0, b_s[k][k*CHUNK +: CHUNK]}
                  + {{CHUNK{1'b0}}, c_s[k]};
            a_d[k] = a_s[k];
            b_d[k] = b_s[k];
            v_d[k] = v_s[k];
            c_d[k] = slice[CHUNK];
            r_d[k] = r_s[k];
            r_d[k][k*CHUNK +: CHUNK] = slice[CHUNK-1:0];
        end
        // Carry into the MSB recovered from the top slice: sum bit = a ^ b ^ cin.
        msb_cin = r_d[STAGES-1][WIDTH-1] ^ a_s[STAGES-1][WIDTH-1] ^ b_s[STAGES-1][WIDTH-1];
        ov_d    = msb_cin ^ c_d[STAGES-1];
`ifdef SATURATE_EN
        if (ov_d) begin
            r_d[STAGES-1] = a_s[STAGES-1][WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                                   : {1'b0, {(WIDTH-1){1'b1}}};
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < STAGES; k++) begin
                a_q[k] <= '0;
                b_q[k] <= '0;
                r_q[k] <= '0;
                c_q[k] <= 1'b0;
                v_q[k] <= 1'b0;
            end
            ov_q <= 1'b0;
        end else if (adv) begin
            a_q  <= a_d;
            b_q  <= b_d;
            r_q  <= r_d;
            c_q  <= c_d;
            v_q  <= v_d;
            ov_q <= ov_d;
        end
    end

    assign out_valid = v_q[STAGES-1];
    assign sum       = r_q[STAGES-1];
    assign carry_out = c_q[STAGES-1];
    assign overflow  = ov_q;
    assign adv       = !out_valid || out_ready;
    assign in_ready  = adv;

    // The last stage's skew copies have no consumer.
    logic unused_skew;
    assign unused_skew = ^{a_q[STAGES-1], b_q[STAGES-1]};

endmodule

// File: tb/tb_pipelined_add_sub.sv
// Bench for pipelined_add_sub (WIDTH=16, CHUNK=4): directed vectors, stall, reset and random traffic
// checked against an arithmetic reference model and an expected-result queue.
module tb_pipelined_add_sub;
    localparam int W      = 16;
    localparam int CH     = 4;
    localparam int STAGES = W / CH;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         mode;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         carry_out;
    logic         overflow;

    int n_checks = 0;
    int n_errors = 0;

    logic [W+1:0] exp_q[$];

    pipelined_add_sub #(.WIDTH(W), .CHUNK(CH)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .mode(mode), .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .carry_out(carry_out), .overflow(overflow)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic logic [W+1:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                           input logic m);
        int sx;
        int sy;
        int sr;
        logic [W-1:0] s;
        logic c;
        logic o;
        sx = $signed(x);
        sy = $signed(y);
        if (!m) begin
            sr = sx + sy;
            s  = x + y;
            c  = (int'(x) + int'(y)) > 65535;
        end else begin
            sr = sx - sy;
            s  = x - y;
            c  = (x >= y);
        end
        o = (sr > 32767) || (sr < -32768);
`ifdef SATURATE_EN
        if (o) s = x[W-1] ? 16'h8000 : 16'h7FFF;
`endif
        return {s, c, o};
    endfunction

    // ---------------- scoreboard / monitor ----------------
    logic         prev_stall = 1'b0;
    logic [W+1:0] prev_res;
    logic [W+1:0] exp_res;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                n_checks++;
                assert ({out_valid, sum, carry_out, overflow} === {1'b1, prev_res}) else begin
                    n_errors++;
                    $error("FAIL hold got v=%b res=%h exp v=1 res=%h", out_valid,
                           {sum, carry_out, overflow}, prev_res);
                end
            end
            if (out_valid && out_ready) begin
                n_checks++;
                assert (exp_q.size() != 0) else begin
                    n_errors++;
                    $error("FAIL unexpected_out got res=%h exp no output", {sum, carry_out, overflow});
                end
                if (exp_q.size() != 0) begin
                    exp_res = exp_q.pop_front();
                    n_checks++;
                    assert ({sum, carry_out, overflow} === exp_res) else begin
                        n_errors++;
                        $error("FAIL result got sum=%h c=%b o=%b exp sum=%h c=%b o=%b", sum,
                               carry_out, overflow, exp_res[W+1:2], exp_res[1], exp_res[0]);
                    end
                end
            end
            if (in_valid && in_ready) exp_q.push_back(model(a, b, mode));
            prev_stall = out_valid && !out_ready;
            prev_res   = {sum, carry_out, overflow};
        end
    end

    // ---------------- driver tasks ----------------
    // Drive one cycle (inputs set just after a rising edge), sample at the falling edge.
    task automatic step(input logic v, input logic [W-1:0] ia, input logic [W-1:0] ib,
                        input logic im, input logic ordy, output logic acc, output logic irdy,
                        output logic ovld, output logic [W+1:0] ores);
        in_valid  = v;
        a         = ia;
        b         = ib;
        mode      = im;
        out_ready = ordy;
        @(negedge clk);
        acc  = v && in_ready;
        irdy = in_ready;
        ovld = out_valid;
        ores = {sum, carry_out, overflow};
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [W+1:0] got, input logic [W+1:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_errors++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Single op on an empty pipe: out_valid must rise exactly STAGES edges after acceptance.
    task automatic check_vec(input string tag, input logic [W-1:0] ia, input logic [W-1:0] ib,
                             input logic im, input logic [W-1:0] es, input logic ec,
                             input logic eo);
        logic acc, irdy, ovld;
        logic [W+1:0] ores;
        step(1'b1, ia, ib, im, 1'b1, acc, irdy, ovld, ores);
        check({tag, "_accept"}, {17'd0, acc}, 18'd1);
        for (int i = 1; i <= STAGES; i++) begin
            step(1'b0, '0, '0, 1'b0, 1'b1, acc, irdy, ovld, ores);
            if (i < STAGES) check({tag, "_early"}, {17'd0, ovld}, 18'd0);
            else begin
                check({tag, "_valid"}, {17'd0, ovld}, 18'd1);
                check({tag, "_res"}, ores, {es, ec, eo});
            end
        end
    endtask

    task automatic drain(input string tag);
        logic acc, irdy, ovld;
        logic [W+1:0] ores;
        for (int i = 0; i < 60 && exp_q.size() != 0; i++)
            step(1'b0, '0, '0, 1'b0, 1'b1, acc, irdy, ovld, ores);
        check({tag, "_drain"}, 18'(exp_q.size()), 18'd0);
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 5))
            0: return 16'h0000;
            1: return 16'hFFFF;
            2: return 16'h7FFF;
            3: return 16'h8000;
            default: return 16'($urandom);
        endcase
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        logic acc, irdy, ovld;
        logic [W+1:0] ores;
        logic [W-1:0] pa, pb;
        logic pm;
        int idx;
        logic [W-1:0] sa[6];
        logic [W-1:0] sb[6];

        rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; mode = 1'b0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset_out", {sum, carry_out, overflow}, 18'd0);
        check("reset_valid", {17'd0, out_valid}, 18'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("reset_ready", {17'd0, in_ready}, 18'd1);

        check_vec("add_basic", 16'h1234, 16'h0FFF, 1'b0, 16'h2233, 1'b0, 1'b0);
        check_vec("add_ripple", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
        check_vec("sub_borrow", 16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        check_vec("sub_equal", 16'h0007, 16'h0007, 1'b1, 16'h0000, 1'b1, 1'b0);
`ifdef SATURATE_EN
        check_vec("add_ovf", 16'h7FFF, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1);
        check_vec("sub_ovf", 16'h8000, 16'h0001, 1'b1, 16'h8000, 1'b1, 1'b1);
`else
        check_vec("add_ovf", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
        check_vec("sub_ovf", 16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1);
`endif
        drain("directed");

        // Six back-to-back ops with out_ready low for three cycles while a result is waiting.
        for (int i = 0; i < 6; i++) begin
            sa[i] = 16'($urandom);
            sb[i] = 16'($urandom);
        end
        idx = 0;
        for (int c = 0; c < 40 && (idx < 6 || exp_q.size() != 0); c++) begin
            pm = idx[0];
            step(idx < 6, (idx < 6) ? sa[idx] : 16'h0, (idx < 6) ? sb[idx] : 16'h0, pm,
                 !(c >= 4 && c < 7), acc, irdy, ovld, ores);
            if (acc) idx++;
            if (c >= 4 && c < 7) check("stall_in_ready", {17'd0, irdy}, {17'd0, !ovld});
        end
        check("stall_all_sent", 18'(idx), 18'd6);
        drain("stall");

        // Reset with three ops in flight.
        for (int i = 0; i < 3; i++) step(1'b1, pick(), pick(), 1'($urandom), 1'b1, acc, irdy, ovld, ores);
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_mid_valid", {17'd0, out_valid}, 18'd0);
        exp_q.delete();
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 6; i++) begin
            step(1'b0, '0, '0, 1'b0, 1'b1, acc, irdy, ovld, ores);
            check("rst_no_stale", {17'd0, ovld}, 18'd0);
        end
        check_vec("after_rst", 16'h1234, 16'h0FFF, 1'b0, 16'h2233, 1'b0, 1'b0);
        drain("after_rst");

        // Random traffic with random bubbles and back-pressure.
        pa = pick(); pb = pick(); pm = 1'($urandom);
        idx = 0;
        for (int c = 0; c < 400; c++) begin
            step(($urandom_range(0, 3) != 0), pa, pb, pm, ($urandom_range(0, 3) != 0),
                 acc, irdy, ovld, ores);
            if (acc) begin
                idx++;
                pa = pick(); pb = pick(); pm = 1'($urandom);
            end
        end
        in_valid = 1'b0;
        drain("random");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
